// File: rtl/cpu_io_pkg.sv
// Shared CPU IO definitions: register map for IO peripherals and
// interrupt-controller state encoding.
package cpu_io_pkg;

  localparam logic [3:0] IOA_MASK     = 4'd0;
  localparam logic [3:0] IOA_PENDING  = 4'd1;
  localparam logic [3:0] IOA_VEC_BASE = 4'd2;

  typedef enum logic [1:0] {
    IC_IDLE    = 2'd0,
    IC_REQ     = 2'd1,
    IC_SERVICE = 2'd2
  } ic_state_e;

endpackage

// File: rtl/irq_sync_edge.sv
// Two-flop synchroniser per IRQ line followed by a rising-edge detector.
module irq_sync_edge #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] irq,
  output logic [N-1:0] rise
);

  logic [N-1:0] s1, s2, s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= irq;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

endmodule

// File: rtl/interrupt_controller.sv
// Interrupt controller on the CPU IO bus: pending/mask state, priority
// vectoring, return-address storage and register access over d_bus.
module interrupt_controller
  import cpu_io_pkg::*;
#(
  parameter int          N_IRQ        = 8,
  parameter int          VEC_SHIFT    = 2,
  parameter logic [15:0] VEC_BASE_RST = 16'h0010
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IRQ-1:0] irq,
  input  logic             io_write,
  input  logic             io_push,
  input  logic [3:0]       io_addr,
  input  logic             io_store_retaddr,
  input  logic             io_push_retaddr,
  input  logic             io_push_ints,
  input  logic             io_push_int_addr,
  output logic             io_interrupt,
  inout  wire  [15:0]      d_bus
);

  localparam int IW = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  ic_state_e        state;
  logic [N_IRQ-1:0] pending, mask, rise, active, clr;
  logic [15:0]      vec_base, retaddr, vec_addr, drv_val, pend_z, mask_z;
  logic [IW-1:0]    idx;
  logic             win_int, win_ret, win_ints, win_reg, ack, drv_en;

  irq_sync_edge #(.N(N_IRQ)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .irq  (irq),
    .rise (rise)
  );

  assign active = pending & ~mask;

  // Walk high to low so the lowest set index is the one left in idx.
  always_comb begin
    idx = '0;
    for (int i = N_IRQ - 1; i >= 0; i--)
      if (active[i]) idx = IW'(i);
  end

  assign vec_addr = (state == IC_REQ) ? vec_base + (16'(idx) << VEC_SHIFT) : vec_base;

  assign win_int  = io_push_int_addr;
  assign win_ret  = io_push_retaddr & ~io_push_int_addr;
  assign win_ints = io_push_ints & ~io_push_retaddr & ~io_push_int_addr;
  assign win_reg  = io_push & ~io_push_ints & ~io_push_retaddr & ~io_push_int_addr;
  assign ack      = win_int & (state == IC_REQ) & (|active);

  always_comb begin
    clr = '0;
    if (ack) clr[idx] = 1'b1;
    if (io_write && io_addr == IOA_PENDING) clr = clr | d_bus[N_IRQ-1:0];
  end

  // A fresh edge is OR-ed in after the clear, so set wins over clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending  <= '0;
      mask     <= '1;
      vec_base <= VEC_BASE_RST;
      retaddr  <= '0;
    end else begin
      pending <= (pending & ~clr) | rise;
      if (io_write) begin
        case (io_addr)
          IOA_MASK:     mask     <= d_bus[N_IRQ-1:0];
          IOA_VEC_BASE: vec_base <= d_bus;
          default: ;
        endcase
      end
      if (io_store_retaddr) retaddr <= d_bus;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IC_IDLE;
      io_interrupt <= 1'b0;
    end else begin
      case (state)
        IC_IDLE: begin
          io_interrupt <= 1'b0;
          if (|active) state <= IC_REQ;
        end
        IC_REQ: begin
          if (ack) begin
            state        <= IC_SERVICE;
            io_interrupt <= 1'b0;
          end else if (!(|active)) begin
            state        <= IC_IDLE;
            io_interrupt <= 1'b0;
          end else begin
            io_interrupt <= 1'b1;
          end
        end
        IC_SERVICE: begin
          io_interrupt <= 1'b0;
          if (win_ret) state <= IC_IDLE;
        end
        default: begin
          state        <= IC_IDLE;
          io_interrupt <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    pend_z = '0;
    mask_z = '0;
    pend_z[N_IRQ-1:0] = pending;
    mask_z[N_IRQ-1:0] = mask;
  end

  always_comb begin
    drv_val = '0;
    if (win_int)       drv_val = vec_addr;
    else if (win_ret)  drv_val = retaddr;
    else if (win_ints) drv_val = pend_z;
    else if (win_reg) begin
      case (io_addr)
        IOA_MASK:     drv_val = mask_z;
        IOA_PENDING:  drv_val = pend_z;
        IOA_VEC_BASE: drv_val = vec_base;
        default:      drv_val = '0;
      endcase
    end
  end

  // Reset releases the bus immediately, even with a strobe held.
  assign drv_en = rst_n & (io_push | io_push_ints | io_push_retaddr | io_push_int_addr);
  assign d_bus  = drv_en ? drv_val : 16'hzzzz;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller: IRQ latency, priority vectoring,
// return address, masking, set-vs-clear race and mid-service reset.
module tb_interrupt_controller;
  import cpu_io_pkg::*;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] irq = '0;
  logic         io_write = 0, io_push = 0, io_store_retaddr = 0;
  logic         io_push_retaddr = 0, io_push_ints = 0, io_push_int_addr = 0;
  logic [3:0]   io_addr = '0;
  logic         io_interrupt;
  wire  [15:0]  d_bus;
  logic         tb_en = 1'b0;
  logic [15:0]  tb_val = '0;
  logic [15:0]  v;
  int           errors = 0;
  int           checks = 0;

  assign d_bus = tb_en ? tb_val : 16'hzzzz;

  interrupt_controller #(.N_IRQ(N), .VEC_SHIFT(2), .VEC_BASE_RST(16'h0010)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .irq             (irq),
    .io_write        (io_write),
    .io_push         (io_push),
    .io_addr         (io_addr),
    .io_store_retaddr(io_store_retaddr),
    .io_push_retaddr (io_push_retaddr),
    .io_push_ints    (io_push_ints),
    .io_push_int_addr(io_push_int_addr),
    .io_interrupt    (io_interrupt),
    .d_bus           (d_bus)
  );

  always #5 clk = ~clk;

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    io_write = 1'b1; io_addr = a; tb_en = 1'b1; tb_val = d;
    @(negedge clk);
    io_write = 1'b0; tb_en = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [15:0] d);
    io_push = 1'b1; io_addr = a;
    #1 d = d_bus;
    io_push = 1'b0;
    #1;
  endtask

  task automatic rd_ints(output logic [15:0] d);
    io_push_ints = 1'b1;
    #1 d = d_bus;
    io_push_ints = 1'b0;
    #1;
  endtask

  task automatic do_ack(output logic [15:0] d);
    io_push_int_addr = 1'b1;
    #1 d = d_bus;
    @(negedge clk);
    io_push_int_addr = 1'b0;
  endtask

  task automatic do_ret(output logic [15:0] d);
    io_push_retaddr = 1'b1;
    #1 d = d_bus;
    @(negedge clk);
    io_push_retaddr = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    io_push = 1'b1; io_addr = IOA_MASK; tb_en = 1'b1; tb_val = 16'h0000;
    #1;
    checks++; if (d_bus !== 16'h0000) begin errors++; $display("FAIL rst_bus_z got=%h exp=0000", d_bus); end
    io_push = 1'b0; tb_en = 1'b0;
    checks++; if (io_interrupt !== 1'b0) begin errors++; $display("FAIL rst_int got=%b exp=0", io_interrupt); end
    rst_n = 1'b1;
    @(negedge clk);
    rd(IOA_MASK, v);
    checks++; if (v !== 16'h00FF) begin errors++; $display("FAIL rst_mask got=%h exp=00ff", v); end
    rd(IOA_PENDING, v);
    checks++; if (v !== 16'h0000) begin errors++; $display("FAIL rst_pending got=%h exp=0000", v); end
    rd(IOA_VEC_BASE, v);
    checks++; if (v !== 16'h0010) begin errors++; $display("FAIL rst_vec_base got=%h exp=0010", v); end
    rd(4'd5, v);
    checks++; if (v !== 16'h0000) begin errors++; $display("FAIL reserved_read got=%h exp=0000", v); end
    do_ret(v);
    checks++; if (v !== 16'h0000) begin errors++; $display("FAIL rst_retaddr got=%h exp=0000", v); end
    wr(4'd3, 16'hFFFF);
    rd(IOA_MASK, v);
    checks++; if (v !== 16'h00FF) begin errors++; $display("FAIL reserved_write_mask got=%h exp=00ff", v); end
    rd(IOA_VEC_BASE, v);
    checks++; if (v !== 16'h0010) begin errors++; $display("FAIL reserved_write_vec got=%h exp=0010", v); end
    io_push_int_addr = 1'b1; io_push = 1'b1; io_addr = IOA_MASK;
    #1 v = d_bus;
    io_push_int_addr = 1'b0; io_push = 1'b0;
    checks++; if (v !== 16'h0010) begin errors++; $display("FAIL bus_priority got=%h exp=0010", v); end
    @(negedge clk);
  endtask

  task automatic test_basic;
    wr(IOA_MASK, 16'h00FE);
    irq[0] = 1'b1;
    repeat (2) @(negedge clk);
    rd(IOA_PENDING, v);
    checks++; if (v !== 16'h0000) begin errors++; $display("FAIL lat_pend_early got=%h exp=0000", v); end
    @(negedge clk);
    rd(IOA_PENDING, v);
    checks++; if (v !== 16'h0001) begin errors++; $display("FAIL lat_pend_set got=%h exp=0001", v); end
    checks++; if (io_interrupt !== 1'b0) begin errors++; $display("FAIL int_idle got=%b exp=0", io_interrupt); end
    @(negedge clk);
    checks++; if (io_interrupt !== 1'b0) begin errors++; $display("FAIL int_req_entry got=%b exp=0", io_interrupt); end
    @(negedge clk);
    checks++; if (io_interrupt !== 1'b1) begin errors++; $display("FAIL int_req got=%b exp=1", io_interrupt); end
    irq = '0;
    do_ack(v);
    checks++; if (v !== 16'h0010) begin errors++; $display("FAIL ack_irq0 got=%h exp=0010", v); end
    checks++; if (io_interrupt !== 1'b0) begin errors++; $display("FAIL int_service got=%b exp=0", io_interrupt); end
    rd(IOA_PENDING, v);
    checks++; if (v !== 16'h0000) begin errors++; $display("FAIL ack_clear got=%h exp=0000", v); end
    do_ret(v);
    @(negedge clk);
  endtask

  task automatic test_priority;
    wr(IOA_MASK, 16'h0000);
    wr(IOA_VEC_BASE, 16'h0100);
    irq = 8'h28;
    repeat (3) @(negedge clk);
    rd(IOA_PENDING, v);
    checks++; if (v !== 16'h0028) begin errors++; $display("FAIL prio_pending got=%h exp=0028", v); end
    repeat (2) @(negedge clk);
    checks++; if (io_interrupt !== 1'b1) begin errors++; $display("FAIL prio_int got=%b exp=1", io_interrupt); end
    irq = '0;
    do_ack(v);
    checks++; if (v !== 16'h010C) begin errors++; $display("FAIL prio_ack3 got=%h exp=010c", v); end
    rd(IOA_PENDING, v);
    checks++; if (v !== 16'h0020) begin errors++; $display("FAIL prio_left got=%h exp=0020", v); end
    @(negedge clk);
    checks++; if (io_interrupt !== 1'b0) begin errors++; $display("FAIL no_nesting got=%b exp=0", io_interrupt); end
    do_ret(v);
    checks++; if (io_interrupt !== 1'b0) begin errors++; $display("FAIL ret_gap1 got=%b exp=0", io_interrupt); end
    @(negedge clk);
    checks++; if (io_interrupt !== 1'b0) begin errors++; $display("FAIL ret_gap2 got=%b exp=0", io_interrupt); end
    @(negedge clk);
    checks++; if (io_interrupt !== 1'b1) begin errors++; $display("FAIL ret_reassert got=%b exp=1", io_interrupt); end
    do_ack(v);
    checks++; if (v !== 16'h0114) begin errors++; $display("FAIL prio_ack5 got=%h exp=0114", v); end
    do_ret(v);
    @(negedge clk);
  endtask

  task automatic test_retaddr;
    irq = 8'h02;
    repeat (5) @(negedge clk);
    irq = '0;
    checks++; if (io_interrupt !== 1'b1) begin errors++; $display("FAIL ra_int got=%b exp=1", io_interrupt); end
    io_store_retaddr = 1'b1; tb_en = 1'b1; tb_val = 16'hBEEF;
    @(negedge clk);
    io_store_retaddr = 1'b0; tb_en = 1'b0;
    do_ack(v);
    checks++; if (v !== 16'h0104) begin errors++; $display("FAIL ra_ack1 got=%h exp=0104", v); end
    do_ret(v);
    checks++; if (v !== 16'hBEEF) begin errors++; $display("FAIL ra_ret got=%h exp=beef", v); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (io_interrupt !== 1'b0) begin errors++; $display("FAIL ra_quiet%0d got=%b exp=0", k, io_interrupt); end
    end
    do_ack(v);
    checks++; if (v !== 16'h0100) begin errors++; $display("FAIL ack_outside_req got=%h exp=0100", v); end
    do_ret(v);
    checks++; if (v !== 16'hBEEF) begin errors++; $display("FAIL ret_outside_service got=%h exp=beef", v); end
    checks++; if (io_interrupt !== 1'b0) begin errors++; $display("FAIL stray_strobes got=%b exp=0", io_interrupt); end
  endtask

  task automatic test_mask;
    irq = 8'h40;
    repeat (5) @(negedge clk);
    irq = '0;
    checks++; if (io_interrupt !== 1'b1) begin errors++; $display("FAIL mask_int got=%b exp=1", io_interrupt); end
    wr(IOA_MASK, 16'hFFFF);
    checks++; if (io_interrupt !== 1'b1) begin errors++; $display("FAIL mask_hold got=%b exp=1", io_interrupt); end
    @(negedge clk);
    checks++; if (io_interrupt !== 1'b0) begin errors++; $display("FAIL mask_drop got=%b exp=0", io_interrupt); end
    do_ack(v);
    checks++; if (v !== 16'h0100) begin errors++; $display("FAIL mask_idle_vec got=%h exp=0100", v); end
    rd(IOA_PENDING, v);
    checks++; if (v !== 16'h0040) begin errors++; $display("FAIL mask_pending got=%h exp=0040", v); end
    wr(IOA_MASK, 16'h0000);
    checks++; if (io_interrupt !== 1'b0) begin errors++; $display("FAIL unmask_gap1 got=%b exp=0", io_interrupt); end
    @(negedge clk);
    checks++; if (io_interrupt !== 1'b0) begin errors++; $display("FAIL unmask_gap2 got=%b exp=0", io_interrupt); end
    @(negedge clk);
    checks++; if (io_interrupt !== 1'b1) begin errors++; $display("FAIL unmask_int got=%b exp=1", io_interrupt); end
    do_ack(v);
    checks++; if (v !== 16'h0118) begin errors++; $display("FAIL mask_ack6 got=%h exp=0118", v); end
    do_ret(v);
    @(negedge clk);
  endtask

  task automatic test_w1c_race;
    wr(IOA_MASK, 16'hFFFF);
    irq = 8'h04;
    repeat (3) @(negedge clk);
    rd(IOA_PENDING, v);
    checks++; if (v !== 16'h0004) begin errors++; $display("FAIL race_pre got=%h exp=0004", v); end
    irq = '0;
    repeat (4) @(negedge clk);
    irq = 8'h04;
    repeat (2) @(negedge clk);
    wr(IOA_PENDING, 16'h0004);
    rd_ints(v);
    checks++; if (v !== 16'h0004) begin errors++; $display("FAIL race_set_wins got=%h exp=0004", v); end
    rd(IOA_PENDING, v);
    checks++; if (v !== 16'h0004) begin errors++; $display("FAIL race_pending got=%h exp=0004", v); end
    irq = '0;
    repeat (4) @(negedge clk);
    wr(IOA_PENDING, 16'h0004);
    rd(IOA_PENDING, v);
    checks++; if (v !== 16'h0000) begin errors++; $display("FAIL w1c_plain got=%h exp=0000", v); end
  endtask

  task automatic test_reset_mid;
    wr(IOA_MASK, 16'h0000);
    irq = 8'h11;
    repeat (5) @(negedge clk);
    irq = '0;
    checks++; if (io_interrupt !== 1'b1) begin errors++; $display("FAIL mid_int got=%b exp=1", io_interrupt); end
    do_ack(v);
    checks++; if (v !== 16'h0100) begin errors++; $display("FAIL mid_ack got=%h exp=0100", v); end
    rst_n = 1'b0;
    #1;
    checks++; if (io_interrupt !== 1'b0) begin errors++; $display("FAIL mid_rst_int got=%b exp=0", io_interrupt); end
    io_push_retaddr = 1'b1; tb_en = 1'b1; tb_val = 16'h0000;
    #1;
    checks++; if (d_bus !== 16'h0000) begin errors++; $display("FAIL mid_rst_bus_z got=%h exp=0000", d_bus); end
    io_push_retaddr = 1'b0; tb_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rd(IOA_PENDING, v);
    checks++; if (v !== 16'h0000) begin errors++; $display("FAIL mid_pending got=%h exp=0000", v); end
    rd(IOA_MASK, v);
    checks++; if (v !== 16'h00FF) begin errors++; $display("FAIL mid_mask got=%h exp=00ff", v); end
    rd(IOA_VEC_BASE, v);
    checks++; if (v !== 16'h0010) begin errors++; $display("FAIL mid_vec_base got=%h exp=0010", v); end
    do_ret(v);
    checks++; if (v !== 16'h0000) begin errors++; $display("FAIL mid_retaddr got=%h exp=0000", v); end
    repeat (2) @(negedge clk);
    checks++; if (io_interrupt !== 1'b0) begin errors++; $display("FAIL mid_quiet got=%b exp=0", io_interrupt); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_priority;
    test_retaddr;
    test_mask;
    test_w1c_race;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
